// File: rtl/frodo_top_ctrl.sv
// Frodo KEM top-level sequencer: issues the LOAD/MATMUL/CODEC/STORE/END
// microprogram for the latched level and mode, guarded by a run watchdog.
module frodo_top_ctrl #(
   parameter int unsigned INST_WIDTH = 27,
   parameter int unsigned ADDR_WIDTH = 12,
   parameter int unsigned TIME       = 100000
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic [1:0]            level,
   input  logic [1:0]            mode_ctrl,
   input  logic                  start,
   output logic [INST_WIDTH-1:0] inst,
   output logic                  inst_valid,
   output logic                  busy,
   output logic                  done,
   output logic                  timeout,
   output logic                  err
);

   localparam int unsigned LEN_W  = 6;
   localparam int unsigned PORT_W = 2;
   localparam int unsigned STEP_W = 3;
   localparam int unsigned CNT_W  = $clog2(TIME + 1);
   localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIME - 2);

   localparam logic [2:0] OP_LOAD  = 3'b000;
   localparam logic [2:0] OP_STORE = 3'b001;
   localparam logic [2:0] OP_MM_AS = 3'b100;
   localparam logic [2:0] OP_MM_SA = 3'b101;
   localparam logic [2:0] OP_CODEC = 3'b110;
   localparam logic [2:0] OP_END   = 3'b111;

   localparam logic [1:0] MODE_KEYGEN   = 2'b00;
   localparam logic [1:0] MODE_ENCAPS   = 2'b01;
   localparam logic [1:0] MODE_ILLEGAL  = 2'b11;
   localparam logic [1:0] LEVEL_ILLEGAL = 2'b00;

   localparam logic [ADDR_WIDTH-1:0] ADDR_IN    = ADDR_WIDTH'(32'h000);
   localparam logic [ADDR_WIDTH-1:0] ADDR_MM    = ADDR_WIDTH'(32'h100);
   localparam logic [ADDR_WIDTH-1:0] ADDR_OUT   = ADDR_WIDTH'(32'h200);
   localparam logic [ADDR_WIDTH-1:0] ADDR_CODEC = ADDR_WIDTH'(32'h300);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_FINISH} state_t;

   state_t              state_q, state_d;
   logic [STEP_W-1:0]   step_q, step_d;
   logic [1:0]          mode_q, mode_d;
   logic [LEN_W-1:0]    len_q, len_d;
   logic [LEN_W-1:0]    wait_q, wait_d;
   logic [CNT_W-1:0]    wd_q, wd_d;
   logic [INST_WIDTH-1:0] inst_d;
   logic                valid_d, busy_d, done_d, timeout_d, err_d;
   logic                last_c;

   function automatic logic [LEN_W-1:0] len_of(input logic [1:0] lv);
      case (lv)
         2'b01:   return LEN_W'(10);
         2'b10:   return LEN_W'(15);
         default: return LEN_W'(21);
      endcase
   endfunction

   function automatic logic [INST_WIDTH-1:0] pack_inst(input logic [2:0]            op,
                                                       input logic [ADDR_WIDTH-1:0] addr,
                                                       input logic [LEN_W-1:0]      len,
                                                       input logic [PORT_W-1:0]     port);
      return INST_WIDTH'({op, addr, len, port, 4'b0000});
   endfunction

   // Microprogram ROM: step index to instruction for the latched mode.
   function automatic logic [INST_WIDTH-1:0] prog_inst(input logic [1:0]        md,
                                                       input logic [STEP_W-1:0] st,
                                                       input logic [LEN_W-1:0]  len);
      logic keygen;
      keygen = (md == MODE_KEYGEN);
      case (st)
         3'd0: return pack_inst(OP_LOAD, ADDR_IN, len, 2'd0);
         3'd1: return pack_inst(keygen ? OP_MM_AS : OP_MM_SA, ADDR_MM, len, 2'd1);
         3'd2: begin
            if (keygen) return pack_inst(OP_STORE, ADDR_OUT, len, 2'd2);
            return pack_inst(OP_CODEC, ADDR_CODEC, len, (md == MODE_ENCAPS) ? 2'd2 : 2'd3);
         end
         3'd3: begin
            if (keygen) return pack_inst(OP_END, '0, '0, '0);
            return pack_inst(OP_STORE, ADDR_OUT, len, (md == MODE_ENCAPS) ? 2'd3 : 2'd2);
         end
         default: return pack_inst(OP_END, '0, '0, '0);
      endcase
   endfunction

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= S_IDLE;
         step_q     <= '0;
         mode_q     <= '0;
         len_q      <= '0;
         wait_q     <= '0;
         wd_q       <= '0;
         inst       <= '0;
         inst_valid <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         timeout    <= 1'b0;
         err        <= 1'b0;
      end else begin
         state_q    <= state_d;
         step_q     <= step_d;
         mode_q     <= mode_d;
         len_q      <= len_d;
         wait_q     <= wait_d;
         wd_q       <= wd_d;
         inst       <= inst_d;
         inst_valid <= valid_d;
         busy       <= busy_d;
         done       <= done_d;
         timeout    <= timeout_d;
         err        <= err_d;
      end
   end

   // Outputs are computed for the state being entered, so they line up with it.
   always_comb begin
      state_d   = state_q;
      step_d    = step_q;
      mode_d    = mode_q;
      len_d     = len_q;
      wait_d    = wait_q;
      wd_d      = wd_q;
      inst_d    = inst;
      valid_d   = 1'b0;
      busy_d    = busy;
      done_d    = 1'b0;
      timeout_d = timeout;
      err_d     = err;
      last_c    = (mode_q == MODE_KEYGEN) ? (step_q == 3'd3) : (step_q == 3'd4);

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               mode_d    = mode_ctrl;
               len_d     = len_of(level);
               step_d    = '0;
               wd_d      = '0;
               err_d     = 1'b0;
               timeout_d = 1'b0;
               if ((level == LEVEL_ILLEGAL) || (mode_ctrl == MODE_ILLEGAL)) begin
                  err_d = 1'b1;
               end else begin
                  state_d = S_ISSUE;
                  busy_d  = 1'b1;
                  valid_d = 1'b1;
                  inst_d  = prog_inst(mode_ctrl, '0, len_of(level));
               end
            end
         end
         S_ISSUE: begin
            if (last_c) begin
               state_d = S_FINISH;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end else begin
               state_d = S_WAIT;
               wait_d  = len_q - LEN_W'(1);
            end
         end
         S_WAIT: begin
            if (wait_q == '0) begin
               state_d = S_ISSUE;
               step_d  = step_q + STEP_W'(1);
               valid_d = 1'b1;
               inst_d  = prog_inst(mode_q, step_q + STEP_W'(1), len_q);
            end else begin
               wait_d = wait_q - LEN_W'(1);
            end
         end
         S_FINISH: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase

      // Watchdog: once END has been issued the run is allowed to complete.
      if ((state_q == S_WAIT) || ((state_q == S_ISSUE) && !last_c)) begin
         if (wd_q == WD_LAST) begin
            state_d   = S_IDLE;
            busy_d    = 1'b0;
            valid_d   = 1'b0;
            done_d    = 1'b0;
            inst_d    = inst;
            timeout_d = 1'b1;
         end else begin
            wd_d = wd_q + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_frodo_top_ctrl.sv
// Directed bench for frodo_top_ctrl: program sequences, illegal configs,
// watchdog abort (TIME=20 instance), ignored restart and mid-run reset.
module tb_frodo_top_ctrl;

   logic        clk;
   logic        rstn;
   logic [1:0]  level;
   logic [1:0]  mode_ctrl;
   logic        start;
   logic [26:0] inst;
   logic        inst_valid, busy, done, timeout, err;
   logic [26:0] wd_inst;
   logic        wd_valid, wd_busy, wd_done, wd_timeout, wd_err;

   int n_chk;
   int n_err;
   logic [26:0] exp_inst [5];

   frodo_top_ctrl u_dut (
      .clk(clk), .rstn(rstn), .level(level), .mode_ctrl(mode_ctrl), .start(start),
      .inst(inst), .inst_valid(inst_valid), .busy(busy), .done(done),
      .timeout(timeout), .err(err)
   );

   frodo_top_ctrl #(.TIME(20)) u_wd (
      .clk(clk), .rstn(rstn), .level(level), .mode_ctrl(mode_ctrl), .start(start),
      .inst(wd_inst), .inst_valid(wd_valid), .busy(wd_busy), .done(wd_done),
      .timeout(wd_timeout), .err(wd_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Pulse start into edge 0; returns at the sample point of cycle 1.
   task automatic start_run(input logic [1:0] lv, input logic [1:0] md);
      @(negedge clk);
      level     = lv;
      mode_ctrl = md;
      start     = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic run_prog(input string tag, input logic [1:0] lv, input logic [1:0] md,
                           input int n, input int per, input int restart_c);
      int idx;
      int done_n;
      int done_c;
      done_c = 1 + (n - 1) * per + 1;
      idx    = 0;
      done_n = 0;
      start_run(lv, md);
      chk({tag, "_err_clr"}, 32'(err), 32'd0);
      chk({tag, "_wd_to_clr"}, 32'(wd_timeout), 32'd0);
      for (int c = 1; c <= done_c + 2; c++) begin
         if (c > 1) begin
            @(posedge clk);
            #1;
         end
         if (c == restart_c) begin
            start     = 1'b1;
            level     = 2'b11;
            mode_ctrl = 2'b10;
         end else if (c == restart_c + 1) begin
            start = 1'b0;
         end
         if (inst_valid) begin
            chk({tag, "_pulse_cyc"}, 32'(c), 32'(1 + idx * per));
            if (idx < 5) chk({tag, "_inst"}, 32'(inst), 32'(exp_inst[idx]));
            idx++;
         end
         if (done) begin
            done_n++;
            chk({tag, "_done_cyc"}, 32'(c), 32'(done_c));
         end
         if (c == 1)          chk({tag, "_busy_first"}, 32'(busy), 32'd1);
         if (c == done_c - 1) chk({tag, "_busy_last"}, 32'(busy), 32'd1);
         if (c == done_c)     chk({tag, "_busy_off"}, 32'(busy), 32'd0);
      end
      chk({tag, "_n_inst"}, 32'(idx), 32'(n));
      chk({tag, "_n_done"}, 32'(done_n), 32'd1);
      chk({tag, "_inst_hold"}, 32'(inst), 32'(exp_inst[n-1]));
   endtask

   task automatic illegal_run(input string tag, input logic [1:0] lv, input logic [1:0] md);
      int pulses;
      pulses = 0;
      start_run(lv, md);
      chk({tag, "_err"}, 32'(err), 32'd1);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_wd_err"}, 32'(wd_err), 32'd1);
      for (int c = 2; c <= 8; c++) begin
         @(posedge clk);
         #1;
         if (inst_valid || busy) pulses++;
      end
      chk({tag, "_no_activity"}, 32'(pulses), 32'd0);
      chk({tag, "_err_sticky"}, 32'(err), 32'd1);
   endtask

   initial begin
      int wd_pulses;
      int wd_dones;
      int act;
      n_chk     = 0;
      n_err     = 0;
      rstn      = 1'b0;
      level     = 2'b00;
      mode_ctrl = 2'b00;
      start     = 1'b0;

      #3;
      chk("rst_inst", 32'(inst), 32'd0);
      chk("rst_valid", 32'(inst_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_flags", 32'({done, timeout, err}), 32'd0);
      repeat (2) @(negedge clk);
      rstn = 1'b1;

      // keygen L1
      exp_inst[0] = 27'h0000280;
      exp_inst[1] = 27'h4100290;
      exp_inst[2] = 27'h12002A0;
      exp_inst[3] = 27'h7000000;
      run_prog("kg_l1", 2'b01, 2'b00, 4, 11, 0);

      illegal_run("ill_lvl", 2'b00, 2'b01);
      illegal_run("ill_mode", 2'b10, 2'b11);

      // encaps L1 (also shows err cleared by a legal start)
      exp_inst[0] = 27'h0000280;
      exp_inst[1] = 27'h5100290;
      exp_inst[2] = 27'h63002A0;
      exp_inst[3] = 27'h12002B0;
      exp_inst[4] = 27'h7000000;
      run_prog("en_l1", 2'b01, 2'b01, 5, 11, 0);

      // decaps L5
      exp_inst[0] = 27'h0000540;
      exp_inst[1] = 27'h5100550;
      exp_inst[2] = 27'h6300570;
      exp_inst[3] = 27'h1200560;
      exp_inst[4] = 27'h7000000;
      run_prog("de_l5", 2'b11, 2'b10, 5, 22, 0);

      // watchdog abort on the TIME=20 instance
      wd_pulses = 0;
      wd_dones  = 0;
      start_run(2'b01, 2'b00);
      for (int c = 1; c <= 40; c++) begin
         if (c > 1) begin
            @(posedge clk);
            #1;
         end
         if (wd_valid) wd_pulses++;
         if (wd_done) wd_dones++;
         if (c == 12) chk("wd_inst2", 32'(wd_inst), 32'h4100290);
         if (c == 19) chk("wd_pre_abort", 32'({wd_busy, wd_timeout}), 32'b10);
         if (c == 20) chk("wd_abort", 32'({wd_busy, wd_timeout}), 32'b01);
      end
      chk("wd_n_inst", 32'(wd_pulses), 32'd2);
      chk("wd_no_done", 32'(wd_dones), 32'd0);
      chk("wd_sticky", 32'(wd_timeout), 32'd1);
      chk("wd_main_no_to", 32'(timeout), 32'd0);

      // restart during a run is ignored
      exp_inst[0] = 27'h0000280;
      exp_inst[1] = 27'h4100290;
      exp_inst[2] = 27'h12002A0;
      exp_inst[3] = 27'h7000000;
      run_prog("restart", 2'b01, 2'b00, 4, 11, 5);

      // reset in the middle of a run
      start_run(2'b01, 2'b00);
      for (int c = 2; c <= 15; c++) begin
         @(posedge clk);
         #1;
      end
      chk("pre_rst_busy", 32'(busy), 32'd1);
      rstn = 1'b0;
      #1;
      chk("mid_rst_inst", 32'(inst), 32'd0);
      chk("mid_rst_ctl", 32'({inst_valid, busy, done, timeout, err}), 32'd0);
      chk("mid_rst_wd", 32'({wd_valid, wd_busy, wd_timeout}), 32'd0);
      @(negedge clk);
      rstn = 1'b1;
      act  = 0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk);
         #1;
         if (inst_valid || busy || done) act++;
      end
      chk("post_rst_idle", 32'(act), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
